kernel_window_reader: RTL and testbench
=======================================

Name: kernel_window_reader

Overview:
- Consumer side of the interlaced row buffer. Accepts a raster-order pixel stream, one pixel per handshake.
- Keeps the two previous rows in internal line buffers. Emits one 3x3 neighbourhood per pixel, with edge replication, to the downstream convolution/filter stage.
- Produces exactly H_PIX*V_PIX windows per frame, in raster order of centre pixel.

Parameters:
- H_PIX, 320, pixels per row.
- V_PIX, 240, rows per frame.
- PIX_W, 24, bits per pixel.
- X_W, $clog2(H_PIX), width of column coordinate.
- Y_W, $clog2(V_PIX), width of row coordinate.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  in_pixel valid.
- in_ready  out  1  block accepts in_pixel this cycle; transfer when in_valid&&in_ready.
- in_pixel  in  PIX_W  raster-order pixel.
- out_valid  out  1  window valid; single-cycle, no downstream backpressure.
- out_x  out  X_W  centre column.
- out_y  out  Y_W  centre row.
- out_window  out  9*PIX_W  element k=3*r+c (r 0=top, c 0=left) at bits [k*PIX_W +: PIX_W].
- frame_done  out  1  pulses with the last window of a frame (centre H_PIX-1,V_PIX-1).

Behaviour:
- Reset values:
  - in_ready=1.
  - out_valid=0, out_x=0, out_y=0, out_window=0, frame_done=0.
  - Column/row counters=0; state=FILL.
  - Line buffer contents need not be cleared.
- Storage:
  - lb_top holds row y-1, lb_mid holds row y (H_PIX x PIX_W each).
  - A 3-column shift register holds the vertical columns (top,mid,bot) for x-2, x-1, x.
- Column formation on accepting pixel p at (x,r):
  - col = {lb_top[x], lb_mid[x], p}.
  - Then lb_top[x]<=lb_mid[x] and lb_mid[x]<=p.
  - For r=1, the top element is clamped to row 0 (col.top = lb_mid[x]).
- Clamping: row -1 is replaced by row 0; row V_PIX is replaced by row V_PIX-1; column -1 by column 0; column H_PIX by column H_PIX-1.
- States:
  - FILL (r=0): in_ready=1; pixels are written to lb_mid only; no output. After the accept at x=H_PIX-1, go to STREAM with r=1.
  - STREAM (1<=r<=V_PIX-1): in_ready=1. An accept at x>=1 emits centre (x-1, r-1), using column x-2 (clamped at x-1=0) and column x. After the accept at x=H_PIX-1, go to EDGE.
  - EDGE: in_ready=0 for exactly one cycle. Emits centre (H_PIX-1, r-1) with the right column clamped. Next state is STREAM with r+1, or FLUSH if r=V_PIX-1.
  - FLUSH: in_ready=0. An internal column counter walks x=0..H_PIX-1 with col = {lb_top[x], lb_mid[x], lb_mid[x]}. Emission follows the STREAM rules for centre row V_PIX-1. After x=H_PIX-1, go to FLUSH_EDGE.
  - FLUSH_EDGE: in_ready=0. Emits centre (H_PIX-1, V_PIX-1) and asserts frame_done with it. Next state is FILL with counters=0.
- Latency: out_valid, out_x, out_y and out_window are registered. They assert exactly 1 cycle after the emitting accept or EDGE/FLUSH cycle.
- in_valid=0 during FILL/STREAM: nothing is accepted, nothing is emitted, and all state holds. Gaps are allowed anywhere in a row.
- in_valid is ignored while in_ready=0; the pixel is not consumed.
- Counter wrap: x wraps H_PIX-1->0 only on the accept or flush step. r wraps on FLUSH_EDGE exit. No out-of-range coordinate is ever output.
- Cycle count per frame with continuous in_valid: H_PIX*V_PIX + (V_PIX-1) + H_PIX + 1 cycles.
- Reset mid-frame: all counters, the state and the outputs return to reset values on the next cycle. Any partial frame is discarded. The next accepted pixel is treated as (0,0).

Test Plan:
- Params H_PIX=4, V_PIX=3, PIX_W=8; pixel value=16*y+x; continuous in_valid:
  - 12 windows in raster order.
  - First window (0,0) = [0,0,1, 0,0,1, 16,16,17], appearing 1 cycle after the accept of pixel (1,1).
  - frame_done exactly once, with (3,2).
- Same stimulus, last window (3,2) = [18,19,19, 34,35,35, 34,35,35].
  - in_ready low 1 cycle after each row-end in rows 1 and 2.
  - in_ready then low 5 cycles for the flush.
  - Total 19 cycles from the first accept to the frame_done cycle (inclusive).
- Random in_valid gaps (50%) over two back-to-back frames:
  - Window contents identical to the continuous run.
  - No window is emitted on a cycle without an accept, EDGE or FLUSH.
  - Second frame restarts at (0,0).
- in_valid held high during EDGE/FLUSH with a changing in_pixel -> those pixels are not consumed; the next accepted pixel becomes (0,r+1) or (0,0).
- Reset asserted after pixel (2,1) -> outputs zero next cycle; a fresh full frame then reproduces the windows of scenario 1 exactly.
- Default parameters (320x240) with random pixels, checked against a software 3x3 clamp model:
  - 76800 windows, all matching.
  - frame_done once per frame.

Source files
------------

// File: rtl/kernel_window_reader.sv
// Streams a raster pixel sequence through two line buffers and emits one
// edge-replicated 3x3 neighbourhood per pixel, in raster order of the centre.
module kernel_window_reader #(
  parameter int unsigned H_PIX = 320,
  parameter int unsigned V_PIX = 240,
  parameter int unsigned PIX_W = 24,
  parameter int unsigned X_W   = $clog2(H_PIX),
  parameter int unsigned Y_W   = $clog2(V_PIX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_pixel,
  output logic                 out_valid,
  output logic [X_W-1:0]       out_x,
  output logic [Y_W-1:0]       out_y,
  output logic [9*PIX_W-1:0]   out_window,
  output logic                 frame_done
);

  localparam int unsigned COL_W = 3 * PIX_W;
  localparam int unsigned WIN_W = 9 * PIX_W;
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIX - 1);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIX - 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_STREAM,
    S_EDGE,
    S_FLUSH,
    S_FLUSH_EDGE
  } state_t;

  state_t             r_state;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic               r_in_ready;
  logic [COL_W-1:0]   r_sr0;
  logic [COL_W-1:0]   r_sr1;
  logic               r_out_valid;
  logic [X_W-1:0]     r_out_x;
  logic [Y_W-1:0]     r_out_y;
  logic [WIN_W-1:0]   r_out_window;
  logic               r_frame_done;

  logic [PIX_W-1:0]   r_lb_top [H_PIX];
  logic [PIX_W-1:0]   r_lb_mid [H_PIX];

  logic [PIX_W-1:0]   w_lb_top;
  logic [PIX_W-1:0]   w_lb_mid;
  logic               w_accept;
  logic               w_step;
  logic               w_edge;
  logic               w_emit;
  logic               w_flush_phase;
  logic [COL_W-1:0]   w_col;
  logic [COL_W-1:0]   w_left;
  logic [COL_W-1:0]   w_mid;
  logic [COL_W-1:0]   w_right;
  logic [WIN_W-1:0]   w_window;

  assign w_lb_top = r_lb_top[r_x];
  assign w_lb_mid = r_lb_mid[r_x];

  // Column formation, left/mid/right selection and window packing
  always_comb begin
    w_accept      = in_valid && r_in_ready;
    w_step        = ((r_state == S_STREAM) && w_accept) || (r_state == S_FLUSH);
    w_edge        = (r_state == S_EDGE) || (r_state == S_FLUSH_EDGE);
    w_emit        = (w_step && (r_x != '0)) || w_edge;
    w_flush_phase = (r_state == S_FLUSH) || (r_state == S_FLUSH_EDGE);
    w_col         = {w_lb_top, w_lb_mid, in_pixel};
    if (r_state == S_FLUSH) begin
      w_col = {w_lb_top, w_lb_mid, w_lb_mid};
    end else if (r_y == Y_ONE) begin
      // row -1 does not exist yet: replicate row 0 upward
      w_col = {w_lb_mid, w_lb_mid, in_pixel};
    end
    w_mid = r_sr1;
    if (w_edge) begin
      w_left  = r_sr0;
      w_right = r_sr1;
    end else begin
      w_left  = (r_x == X_ONE) ? r_sr1 : r_sr0;
      w_right = w_col;
    end
    w_window = '0;
    for (int rr = 0; rr < 3; rr++) begin
      w_window[(3*rr)*PIX_W   +: PIX_W] = w_left [(2-rr)*PIX_W +: PIX_W];
      w_window[(3*rr+1)*PIX_W +: PIX_W] = w_mid  [(2-rr)*PIX_W +: PIX_W];
      w_window[(3*rr+2)*PIX_W +: PIX_W] = w_right[(2-rr)*PIX_W +: PIX_W];
    end
  end

  // Line buffers age by one row at each accepted column; no reset needed
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      if (r_state == S_STREAM) begin
        r_lb_top[r_x] <= w_lb_mid;
      end
      r_lb_mid[r_x] <= in_pixel;
    end
  end

  // Frame sequencing, column shift register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FILL;
      r_x          <= '0;
      r_y          <= '0;
      r_in_ready   <= 1'b1;
      r_sr0        <= '0;
      r_sr1        <= '0;
      r_out_valid  <= 1'b0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_window <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_frame_done <= (r_state == S_FLUSH_EDGE);
      if (w_emit) begin
        r_out_x      <= w_edge ? X_LAST : (r_x - X_ONE);
        r_out_y      <= w_flush_phase ? Y_LAST : (r_y - Y_ONE);
        r_out_window <= w_window;
      end
      if (w_step) begin
        r_sr0 <= r_sr1;
        r_sr1 <= w_col;
      end
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (r_x == X_LAST) begin
              r_x     <= '0;
              r_y     <= Y_ONE;
              r_state <= S_STREAM;
            end else begin
              r_x <= r_x + X_ONE;
            end
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            if (r_x == X_LAST) begin
              r_x        <= '0;
              r_state    <= S_EDGE;
              r_in_ready <= 1'b0;
            end else begin
              r_x <= r_x + X_ONE;
            end
          end
        end
        S_EDGE: begin
          if (r_y == Y_LAST) begin
            r_state <= S_FLUSH;
          end else begin
            r_y        <= r_y + Y_ONE;
            r_state    <= S_STREAM;
            r_in_ready <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_x == X_LAST) begin
            r_x     <= '0;
            r_state <= S_FLUSH_EDGE;
          end else begin
            r_x <= r_x + X_ONE;
          end
        end
        S_FLUSH_EDGE: begin
          r_x        <= '0;
          r_y        <= '0;
          r_state    <= S_FILL;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_x        <= '0;
          r_y        <= '0;
          r_state    <= S_FILL;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_x      = r_out_x;
  assign out_y      = r_out_y;
  assign out_window = r_out_window;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_kernel_window_reader.sv
// Bench for kernel_window_reader: a small 4x3 instance and a default 320x240
// instance, both checked every cycle against a frame-array clamp model.
module tb_kernel_window_reader;

  localparam int unsigned SH = 4;
  localparam int unsigned SV = 3;
  localparam int unsigned SW = 8;
  localparam int unsigned BH = 320;
  localparam int unsigned BV = 240;
  localparam int unsigned BW = 24;
  localparam int unsigned SXW = $clog2(SH);
  localparam int unsigned SYW = $clog2(SV);
  localparam int unsigned BXW = $clog2(BH);
  localparam int unsigned BYW = $clog2(BV);
  localparam int unsigned WW  = 9 * BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic [BW-1:0] in_pixel;
  logic          sel;

  logic s_in_valid, s_in_ready, s_out_valid, s_fd;
  logic [SXW-1:0] s_out_x;
  logic [SYW-1:0] s_out_y;
  logic [9*SW-1:0] s_win;
  logic b_in_valid, b_in_ready, b_out_valid, b_fd;
  logic [BXW-1:0] b_out_x;
  logic [BYW-1:0] b_out_y;
  logic [9*BW-1:0] b_win;

  assign s_in_valid = in_valid && !sel;
  assign b_in_valid = in_valid && sel;

  kernel_window_reader #(.H_PIX(SH), .V_PIX(SV), .PIX_W(SW)) u_small (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pixel(in_pixel[SW-1:0]), .out_valid(s_out_valid), .out_x(s_out_x),
    .out_y(s_out_y), .out_window(s_win), .frame_done(s_fd)
  );

  kernel_window_reader u_big (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pixel(in_pixel), .out_valid(b_out_valid), .out_x(b_out_x),
    .out_y(b_out_y), .out_window(b_win), .frame_done(b_fd)
  );

  logic          u_in_ready, u_out_valid, u_fd;
  int            u_x, u_y;
  logic [WW-1:0] u_win;
  int            cur_h, cur_v, cur_w;

  assign u_in_ready  = sel ? b_in_ready : s_in_ready;
  assign u_out_valid = sel ? b_out_valid : s_out_valid;
  assign u_fd        = sel ? b_fd : s_fd;
  assign u_x         = sel ? int'(b_out_x) : int'(s_out_x);
  assign u_y         = sel ? int'(b_out_y) : int'(s_out_y);
  assign u_win       = sel ? b_win : WW'(s_win);
  assign cur_h       = sel ? int'(BH) : int'(SH);
  assign cur_v       = sel ? int'(BV) : int'(SV);
  assign cur_w       = sel ? int'(BW) : int'(SW);

  // Model: whole frame in an array, plus a queue of forced no-accept cycles
  typedef struct { bit em; int cx; int cy; bit fd; } ev_t;
  int unsigned frame_mem [BH*BV];
  ev_t         stall_q[$];
  int          ax, ay;
  bit          chk_en;
  int          checks, errors, cyc;
  int          win_cnt, fd_cnt, rdy_low, first_acc, first_win, fd_cyc;
  int          fd_x, fd_y, zero_cnt;
  logic [WW-1:0] obs0, obs_last;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned elem(input int cx, input int cy, input int k);
    int yy, xx;
    yy = cy + k / 3 - 1;
    xx = cx + k % 3 - 1;
    if (yy < 0) yy = 0;
    if (yy > cur_v - 1) yy = cur_v - 1;
    if (xx < 0) xx = 0;
    if (xx > cur_h - 1) xx = cur_h - 1;
    return frame_mem[yy * cur_h + xx];
  endfunction

  function automatic logic [WW-1:0] exp_window(input int cx, input int cy);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w = w | (WW'(elem(cx, cy, k)) << (k * cur_w));
    return w;
  endfunction

  function automatic logic [WW-1:0] pack8(input int v[9]);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w = w | (WW'(v[k]) << (k * 8));
    return w;
  endfunction

  // Compare process: advance the model on each edge, check outputs 1 ns later
  always @(posedge clk) begin
    bit e_v, e_fd, e_rst;
    int e_x, e_y;
    ev_t ev;
    cyc++;
    e_v = 0; e_fd = 0; e_rst = 0; e_x = 0; e_y = 0;
    if (chk_en) begin
      if (reset) begin
        stall_q.delete();
        ax = 0; ay = 0; e_rst = 1;
      end else if (stall_q.size() > 0) begin
        ev = stall_q.pop_front();
        e_v = ev.em; e_x = ev.cx; e_y = ev.cy; e_fd = ev.fd;
      end else if (in_valid) begin
        if (first_acc < 0) first_acc = cyc;
        frame_mem[ay * cur_h + ax] = int'(in_pixel) & ((1 << cur_w) - 1);
        if (ay >= 1 && ax >= 1) begin e_v = 1; e_x = ax - 1; e_y = ay - 1; end
        if (ax == cur_h - 1 && ay >= 1) begin
          stall_q.push_back('{1'b1, cur_h - 1, ay - 1, 1'b0});
          if (ay == cur_v - 1) begin
            stall_q.push_back('{1'b0, 0, 0, 1'b0});
            for (int i = 0; i < cur_h - 1; i++) stall_q.push_back('{1'b1, i, cur_v - 1, 1'b0});
            stall_q.push_back('{1'b1, cur_h - 1, cur_v - 1, 1'b1});
          end
        end
        ax++;
        if (ax == cur_h) begin
          ax = 0; ay++;
          if (ay == cur_v) ay = 0;
        end
      end
      #1;
      chk("in_ready", WW'(u_in_ready), WW'(stall_q.size() == 0));
      chk("out_valid", WW'(u_out_valid), WW'(e_v));
      chk("frame_done", WW'(u_fd), WW'(e_fd));
      if (e_v && u_out_valid) begin
        chk("out_x", WW'(u_x), WW'(e_x));
        chk("out_y", WW'(u_y), WW'(e_y));
        chk("out_window", u_win, exp_window(e_x, e_y));
      end
      if (e_rst) begin
        chk("rst_out_x", WW'(u_x), '0);
        chk("rst_out_y", WW'(u_y), '0);
        chk("rst_window", u_win, '0);
      end
      if (first_acc >= 0 && fd_cnt == 0 && !u_in_ready) rdy_low++;
      if (u_out_valid) begin
        win_cnt++;
        if (first_win < 0) first_win = cyc;
        if (u_x == 0 && u_y == 0) begin obs0 = u_win; zero_cnt++; end
        if (u_x == cur_h - 1 && u_y == cur_v - 1) obs_last = u_win;
      end
      if (u_fd) begin
        fd_cnt++; fd_cyc = cyc; fd_x = u_x; fd_y = u_y;
      end
    end
  end

  task automatic clear_stats();
    win_cnt = 0; fd_cnt = 0; rdy_low = 0; first_acc = -1; first_win = -1;
    fd_cyc = -1; fd_x = -1; fd_y = -1; zero_cnt = 0; obs0 = '0; obs_last = '0;
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Offers one pixel; junk with in_valid high while the block is stalled
  task automatic send(input logic [BW-1:0] p, input bit gaps);
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (gaps && $urandom_range(1) == 0) begin
        in_valid = 1'b0; in_pixel = BW'($urandom);
      end else if (!u_in_ready) begin
        in_valid = 1'b1; in_pixel = BW'($urandom);
      end else begin
        in_valid = 1'b1; in_pixel = p;
        @(posedge clk);
        return;
      end
      guard++;
      if (guard > 2000) begin
        errors++;
        $display("FAIL send_timeout: in_ready got 0 expected 1 within 2000 cycles");
        finish_run();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_pixel = BW'($urandom);
    end
  endtask

  task automatic send_frame(input bit rnd, input bit gaps);
    for (int y = 0; y < cur_v; y++)
      for (int x = 0; x < cur_w * 0 + cur_h; x++)
        send(rnd ? BW'($urandom) : BW'(16 * y + x), gaps);
  endtask

  task automatic small_frame_checks(input string tag);
    chk({tag, "_win_cnt"}, WW'(win_cnt), WW'(12));
    chk({tag, "_fd_cnt"}, WW'(fd_cnt), WW'(1));
    chk({tag, "_fd_x"}, WW'(fd_x), WW'(3));
    chk({tag, "_fd_y"}, WW'(fd_y), WW'(2));
    chk({tag, "_first_win"}, obs0, pack8('{0, 0, 1, 0, 0, 1, 16, 16, 17}));
    chk({tag, "_last_win"}, obs_last, pack8('{18, 19, 19, 34, 35, 35, 34, 35, 35}));
    chk({tag, "_first_lat"}, WW'(first_win - first_acc), WW'(5));
    chk({tag, "_frame_cycles"}, WW'(fd_cyc - first_acc + 1), WW'(19));
    chk({tag, "_ready_low"}, WW'(rdy_low), WW'(7));
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; in_valid = 1'b0; in_pixel = '0;
    chk_en = 0; checks = 0; errors = 0; cyc = 0; ax = 0; ay = 0;
    clear_stats();
    repeat (2) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("reset_in_ready", WW'(u_in_ready), WW'(1));
    chk("reset_out_valid", WW'(u_out_valid), WW'(0));
    reset = 1'b0;

    // 4x3 continuous frame
    clear_stats();
    send_frame(1'b0, 1'b0);
    idle(8);
    small_frame_checks("cont");

    // two back-to-back frames with random gaps
    clear_stats();
    send_frame(1'b0, 1'b1);
    send_frame(1'b0, 1'b1);
    idle(8);
    chk("gap_win_cnt", WW'(win_cnt), WW'(24));
    chk("gap_fd_cnt", WW'(fd_cnt), WW'(2));
    chk("gap_origin_cnt", WW'(zero_cnt), WW'(2));
    chk("gap_last_win", obs_last, pack8('{18, 19, 19, 34, 35, 35, 34, 35, 35}));

    // reset after pixel (2,1), then a clean frame
    clear_stats();
    for (int i = 0; i < 7; i++) send(BW'(16 * (i / 4) + i % 4), 1'b0);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", WW'(u_out_valid), WW'(0));
    chk("midrst_window", u_win, '0);
    reset = 1'b0;
    clear_stats();
    send_frame(1'b0, 1'b0);
    idle(8);
    small_frame_checks("rerun");

    // full-size frame with random pixels
    @(negedge clk);
    reset = 1'b1; sel = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    send_frame(1'b1, 1'b0);
    idle(int'(BH) + 10);
    chk("big_win_cnt", WW'(win_cnt), WW'(BH * BV));
    chk("big_fd_cnt", WW'(fd_cnt), WW'(1));
    finish_run();
  end

endmodule
